axist_slv_buf: RTL and testbench
================================

// Module: axist_slv_buf
// PURPOSE
//  Synthesizable AXI-Stream slave (receiver) terminating a stream driven by the team's axist master BFM.
//  - Accepts beats (dout/last under valid/ready) into a FWFT FIFO; presents them on a pop interface.
//  - Tracks packet boundaries; reports the number of complete packets buffered.
//  - Sits at the ingress of any datapath that consumes axist packets.
// PARAMETERS
//  DATA_WIDTH   8    beat payload width; matches master dout width
//  DEPTH        16   FIFO entries; power of two, >=2
//  MAX_PKT_LEN  256  max beats per packet; used only with AXIST_SLV_LEN_CHECK_EN; >=1
// PORTS
//  clk        in   1                   single clock, rising edge
//  rst_n      in   1                   asynchronous reset, active low
//  valid      in   1                   master beat valid
//  last       in   1                   final beat of packet
//  din        in   DATA_WIDTH          beat payload
//  ready      out  1                   slave can accept beat (registered)
//  rd_en      in   1                   consumer pops head entry
//  rd_valid   out  1                   head entry present (level != 0)
//  rd_data    out  DATA_WIDTH          head payload (FWFT)
//  rd_last    out  1                   head entry is packet end
//  level      out  $clog2(DEPTH)+1     entries stored
//  pkt_cnt    out  $clog2(DEPTH)+1     complete packets stored (entries with last=1)
//  err_len    out  1                   one-cycle pulse, over-length packet truncated
// BEHAVIOUR
//  - Reset (async assert, sync release): ready=0, rd_valid=0, rd_data=0, rd_last=0, level=0, pkt_cnt=0,
//    err_len=0, FSM=IDLE. ready rises on the first clk edge after release. Mid-packet reset discards
//    the partial packet and all stored entries.
//  - Accept = valid & ready at posedge. ready has no combinational path from valid.
//  - ready_q <= (next_level != DEPTH) || (next_state == DROP). When full, a same-cycle pop does not
//    allow a push; ready reasserts the cycle after level drops below DEPTH.
//  - Latency: an accepted beat is visible on rd_* the next cycle. Pop = rd_en & rd_valid;
//    rd_en while empty is ignored, with no state change.
//  - level and pkt_cnt: push & pop in the same cycle leaves level unchanged.
//    pkt_cnt +1 on push with stored last=1, -1 on pop with rd_last=1; both together leave it unchanged.
//  - Pointers wrap modulo DEPTH; level is never > DEPTH and never < 0.
//  - FSM, advanced on accepted beats only:
//      IDLE --beat, last=0--> IN_PKT (beat_cnt=1)
//      IDLE --beat, last=1--> IDLE (single-beat packet)
//      IN_PKT --beat, last=1--> IDLE; IN_PKT --beat, last=0--> IN_PKT, beat_cnt+1
//      DROP --beat, last=1--> IDLE; DROP --beat, last=0--> DROP
//    DROP is reachable only with the macro. beat_cnt saturates at MAX_PKT_LEN.
// CONFIGURATION
//  AXIST_SLV_LEN_CHECK_EN defined:
//    - Beat number MAX_PKT_LEN of a packet accepted with last=0 is stored with last forced to 1.
//    - err_len pulses for 1 cycle and the FSM enters DROP.
//    - In DROP, ready=1 and beats are accepted but not stored, through the beat with last=1.
//  AXIST_SLV_LEN_CHECK_EN undefined: no length limit, DROP unused, err_len tied 0, no beat_cnt logic.
// STRUCTURE
//  - axist_pkg: rx_state_e enum {IDLE, IN_PKT, DROP}; localparam-free helper function for level width.
//  - Sub-module axist_sync_fifo: storage {last,data}, DEPTH entries, FWFT, wr_en/rd_en/level.
//  - Top level owns the FSM, ready register, pkt_cnt, and length check.
// TESTING (bench uses axist_mst as driver)
//  - Reset release: ready=0 in reset, 1 at first edge after; rd_valid=0, level=0.
//  - write_issue 4 beats {11,22,33,44}, rd_en=0: level=4, pkt_cnt=1, rd_data=11; pops return
//    11,22,33,44 with rd_last only on 44.
//  - DEPTH=16, 20-beat packet, rd_en=0: ready drops after 16 accepts. Pop one: ready returns next
//    cycle; all 20 beats arrive in order.
//  - Full FIFO with valid=1 and rd_en=1 in the same cycle: level goes 16->15, no push that cycle.
//  - rd_en held 1 while streaming: push+pop each cycle keeps level=1; pkt_cnt 1->0 on last pop.
//  - Macro on, MAX_PKT_LEN=4, 6-beat packet {1..6}: stored 1,2,3,4 with rd_last on 4; err_len
//    pulses once; beats 5,6 dropped; next packet received intact.

Source files
------------

// File: rtl/axist_pkg.sv
// Shared types and helpers for the axist stream-slave receive path.
package axist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        DROP   = 2'd2
    } rx_state_e;

    // Width needed to count 0..depth entries inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axist_sync_fifo.sv
// First-word-fall-through FIFO holding {last, data} beats.
// Head entry is visible on rd_* whenever the FIFO is non-empty.
module axist_sync_fifo
    import axist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int LW        = lvl_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic [LW-1:0]         level
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH:0] mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                push, pop;

    assign push = wr_en & (level_q != LW'(DEPTH));
    assign pop  = rd_en & (level_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage has no reset; outputs are gated to zero while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {wr_last, wr_data};
    end

    assign rd_valid = (level_q != '0);
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q][DATA_WIDTH-1:0] : '0;
    assign rd_last  = rd_valid ? mem_q[rd_ptr_q][DATA_WIDTH] : 1'b0;
    assign level    = level_q;

endmodule

// File: rtl/axist_slv_buf.sv
// AXI-Stream slave buffer: FWFT beat FIFO with packet tracking.
// Optional over-length truncation enabled by AXIST_SLV_LEN_CHECK_EN.
module axist_slv_buf
    import axist_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int MAX_PKT_LEN = 256,
    localparam int LW         = lvl_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic                  last,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  ready,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic [LW-1:0]         level,
    output logic [LW-1:0]         pkt_cnt,
    output logic                  err_len
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axist_slv_buf: DEPTH must be a power of two >= 2");
    end
    if (MAX_PKT_LEN < 1) begin : g_bad_len
        $error("axist_slv_buf: MAX_PKT_LEN must be >= 1");
    end

    rx_state_e     state_q, state_d;
    logic          ready_q, ready_d;
    logic [LW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [LW-1:0] level_nxt;
    logic          accept, push, pop, trunc, store_last;

    assign accept     = valid & ready_q;
    assign push       = accept & (state_q != DROP);
    assign pop        = rd_en & rd_valid;
    assign store_last = last | trunc;

`ifdef AXIST_SLV_LEN_CHECK_EN
    localparam int BW = $clog2(MAX_PKT_LEN + 1);

    logic [BW-1:0] beat_cnt_q, beat_cnt_d, beat_num;
    logic          err_len_q;

    // Ordinal of the beat being accepted, saturating at MAX_PKT_LEN.
    always_comb begin
        beat_num = BW'(1);
        if (state_q == IN_PKT) begin
            beat_num = (beat_cnt_q == BW'(MAX_PKT_LEN)) ? beat_cnt_q : beat_cnt_q + 1'b1;
        end
        beat_cnt_d = push ? beat_num : beat_cnt_q;
    end

    assign trunc = push & ~last & (beat_num == BW'(MAX_PKT_LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            err_len_q  <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            err_len_q  <= trunc;
        end
    end

    assign err_len = err_len_q;
`else
    assign trunc   = 1'b0;
    assign err_len = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                IDLE, IN_PKT: begin
                    if (last)       state_d = IDLE;
                    else if (trunc) state_d = DROP;
                    else            state_d = IN_PKT;
                end
                DROP:    if (last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ready is registered from the post-edge occupancy, so a pop while full
    // only reopens the input on the following cycle.
    always_comb begin
        level_nxt = level + LW'(push) - LW'(pop);
        ready_d   = (level_nxt != LW'(DEPTH)) || (state_d == DROP);
        pkt_cnt_d = pkt_cnt_q + LW'(push & store_last) - LW'(pop & rd_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    axist_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (push),
        .wr_data  (din),
        .wr_last  (store_last),
        .rd_en    (rd_en),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .level    (level)
    );

    assign ready   = ready_q;
    assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_axist_slv_buf.sv
// Directed self-checking bench for axist_slv_buf (DEPTH=16, 8-bit beats).
module tb_axist_slv_buf;

`ifdef AXIST_SLV_LEN_CHECK_EN
    localparam int MAXP = 4;
`else
    localparam int MAXP = 256;
`endif

    logic       clk, rst_n;
    logic       valid, last, rd_en;
    logic [7:0] din;
    logic       ready, rd_valid, rd_last, err_len;
    logic [7:0] rd_data;
    logic [4:0] level, pkt_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    axist_slv_buf #(
        .DATA_WIDTH  (8),
        .DEPTH       (16),
        .MAX_PKT_LEN (MAXP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid),
        .last     (last),
        .din      (din),
        .ready    (ready),
        .rd_en    (rd_en),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .level    (level),
        .pkt_cnt  (pkt_cnt),
        .err_len  (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        int n;
        din   = d;
        last  = l;
        valid = 1'b1;
        n = 0;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk("ready_wait", {31'd0, ready}, 32'd1);
        tick();
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic pop(input logic [7:0] d, input logic l);
        chk("pop_valid", {31'd0, rd_valid}, 32'd1);
        chk("pop_data", {24'd0, rd_data}, {24'd0, d});
        chk("pop_last", {31'd0, rd_last}, {31'd0, l});
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; valid = 1'b0; last = 1'b0; din = '0; rd_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
        chk("rst_rd_last", {31'd0, rd_last}, 32'd0);
        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_pkt_cnt", {27'd0, pkt_cnt}, 32'd0);
        chk("rst_err_len", {31'd0, err_len}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_ready_low", {31'd0, ready}, 32'd0);
        tick();
        chk("release_ready_high", {31'd0, ready}, 32'd1);
        chk("release_level", {27'd0, level}, 32'd0);

        // Four-beat packet, no consumer
        push(8'd11, 1'b0);
        push(8'd22, 1'b0);
        push(8'd33, 1'b0);
        push(8'd44, 1'b1);
        chk("p4_level", {27'd0, level}, 32'd4);
        chk("p4_pkt_cnt", {27'd0, pkt_cnt}, 32'd1);
        chk("p4_head", {24'd0, rd_data}, 32'd11);
        pop(8'd11, 1'b0);
        pop(8'd22, 1'b0);
        pop(8'd33, 1'b0);
        pop(8'd44, 1'b1);
        chk("p4_level_end", {27'd0, level}, 32'd0);
        chk("p4_pkt_end", {27'd0, pkt_cnt}, 32'd0);
        chk("p4_rd_valid_end", {31'd0, rd_valid}, 32'd0);

        // Pop while empty is ignored
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("empty_pop_level", {27'd0, level}, 32'd0);
        chk("empty_pop_pkt", {27'd0, pkt_cnt}, 32'd0);
        chk("empty_pop_data", {24'd0, rd_data}, 32'd0);

`ifndef AXIST_SLV_LEN_CHECK_EN
        // 20-beat packet into a 16-entry FIFO
        for (int i = 0; i < 16; i++) push(8'(100 + i), 1'b0);
        chk("full_level", {27'd0, level}, 32'd16);
        chk("full_ready", {31'd0, ready}, 32'd0);
        chk("full_pkt_cnt", {27'd0, pkt_cnt}, 32'd0);
        din = 8'd116; last = 1'b0; valid = 1'b1;
        tick();
        chk("full_hold_level", {27'd0, level}, 32'd16);
        chk("full_hold_ready", {31'd0, ready}, 32'd0);
        chk("full_head", {24'd0, rd_data}, 32'd100);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("full_pop_level", {27'd0, level}, 32'd15);
        chk("full_pop_ready", {31'd0, ready}, 32'd1);
        chk("full_pop_head", {24'd0, rd_data}, 32'd101);
        tick();
        valid = 1'b0;
        chk("refill_level", {27'd0, level}, 32'd16);
        chk("refill_ready", {31'd0, ready}, 32'd0);
        for (int i = 1; i <= 16; i++) pop(8'(100 + i), 1'b0);
        push(8'd117, 1'b0);
        push(8'd118, 1'b0);
        push(8'd119, 1'b1);
        chk("p20_pkt_cnt", {27'd0, pkt_cnt}, 32'd1);
        pop(8'd117, 1'b0);
        pop(8'd118, 1'b0);
        pop(8'd119, 1'b1);
        chk("p20_level_end", {27'd0, level}, 32'd0);
        chk("p20_pkt_end", {27'd0, pkt_cnt}, 32'd0);
`endif

        // Streaming with consumer always ready
        rd_en = 1'b1; valid = 1'b1; din = 8'd50; last = 1'b0;
        tick();
        chk("stream1_level", {27'd0, level}, 32'd1);
        chk("stream1_data", {24'd0, rd_data}, 32'd50);
        din = 8'd51;
        tick();
        chk("stream2_level", {27'd0, level}, 32'd1);
        chk("stream2_data", {24'd0, rd_data}, 32'd51);
        chk("stream2_pkt", {27'd0, pkt_cnt}, 32'd0);
        din = 8'd52; last = 1'b1;
        tick();
        chk("stream3_level", {27'd0, level}, 32'd1);
        chk("stream3_data", {24'd0, rd_data}, 32'd52);
        chk("stream3_last", {31'd0, rd_last}, 32'd1);
        chk("stream3_pkt", {27'd0, pkt_cnt}, 32'd1);
        valid = 1'b0; last = 1'b0;
        tick();
        rd_en = 1'b0;
        chk("stream_end_level", {27'd0, level}, 32'd0);
        chk("stream_end_pkt", {27'd0, pkt_cnt}, 32'd0);
        chk("stream_err_len", {31'd0, err_len}, 32'd0);

`ifdef AXIST_SLV_LEN_CHECK_EN
        // Six-beat packet against a four-beat limit
        push(8'd1, 1'b0);
        push(8'd2, 1'b0);
        push(8'd3, 1'b0);
        push(8'd4, 1'b0);
        chk("trunc_err_pulse", {31'd0, err_len}, 32'd1);
        chk("trunc_level", {27'd0, level}, 32'd4);
        chk("trunc_pkt", {27'd0, pkt_cnt}, 32'd1);
        push(8'd5, 1'b0);
        chk("drop_err_clear", {31'd0, err_len}, 32'd0);
        chk("drop_level5", {27'd0, level}, 32'd4);
        push(8'd6, 1'b1);
        chk("drop_level6", {27'd0, level}, 32'd4);
        push(8'd7, 1'b0);
        push(8'd8, 1'b1);
        chk("next_pkt_level", {27'd0, level}, 32'd6);
        chk("next_pkt_cnt", {27'd0, pkt_cnt}, 32'd2);
        pop(8'd1, 1'b0);
        pop(8'd2, 1'b0);
        pop(8'd3, 1'b0);
        pop(8'd4, 1'b1);
        pop(8'd7, 1'b0);
        pop(8'd8, 1'b1);
        chk("trunc_end_pkt", {27'd0, pkt_cnt}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
